// File: rtl/ctrl_pkg.sv
// Shared encodings and stage bundles for the ctrl_pipe control pipeline.
// Defining CTRL_PIPE_FWD_EN switches hazard handling from stalls to forwarding.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_IMM   = 2'b11
  } aluop_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int CTRL_W = 8;

  typedef struct packed {
    logic   regdst;
    logic   regw;
    logic   alusrc;
    logic   memw;
    logic   memr;
    logic   memtoreg;
    aluop_e aluop;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic       memw;
    logic       memr;
    logic       regw;
    logic       memtoreg;
    logic [4:0] wreg;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    logic       regw;
    logic       memtoreg;
    logic [4:0] wreg;
  } mem_wb_t;

  // r0 is hardwired to zero, so it never creates a dependency
  function automatic logic reg_hit(
    logic       en,
    logic [4:0] dst,
    logic [4:0] src
  );
    return en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use / RAW stall detection and EX operand forwarding selects.
// Forwarding muxes exist only when CTRL_PIPE_FWD_EN is defined.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  input  logic       ex_valid,
  input  logic       ex_RegW,
  input  logic       ex_MemR,
  input  logic [4:0] ex_wreg,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_valid,
  input  logic       mem_RegW,
  input  logic [4:0] mem_wreg,
  input  logic       wb_valid,
  input  logic       wb_RegW,
  input  logic [4:0] wb_wreg,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic ex_ld;
  logic mem_wr;
  logic ld_use;
  logic raw;

  assign ex_ld  = ex_valid & ex_MemR;
  assign mem_wr = mem_valid & mem_RegW;

  assign ld_use = reg_hit(ex_ld, ex_wreg, id_rs)
                | reg_hit(ex_ld, ex_wreg, id_rt);

`ifdef CTRL_PIPE_FWD_EN
  logic wb_wr;

  assign wb_wr = wb_valid & wb_RegW;
  assign raw   = 1'b0;

  // MEM holds the younger result, so it wins over WB
  always_comb begin
    fwd_a = FWD_RF;
    if (reg_hit(mem_wr, mem_wreg, ex_rs))
      fwd_a = FWD_MEM;
    else if (reg_hit(wb_wr, wb_wreg, ex_rs))
      fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (reg_hit(mem_wr, mem_wreg, ex_rt))
      fwd_b = FWD_MEM;
    else if (reg_hit(wb_wr, wb_wreg, ex_rt))
      fwd_b = FWD_WB;
  end
`else
  logic ex_wr;
  logic unused_fwd;

  assign ex_wr = ex_valid & ex_RegW;

  // WB is covered by the write-first regfile
  assign raw = reg_hit(ex_wr, ex_wreg, id_rs)
             | reg_hit(ex_wr, ex_wreg, id_rt)
             | reg_hit(mem_wr, mem_wreg, id_rs)
             | reg_hit(mem_wr, mem_wreg, id_rt);

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  assign unused_fwd = ^{ex_rs, ex_rt, wb_valid,
                        wb_RegW, wb_wreg};
`endif

  assign stall = id_valid & ~flush & (ld_use | raw);

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard handling.
// Build option: CTRL_PIPE_FWD_EN enables forwarding instead of RAW stalls.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic       id_Regdst,
  input  logic       id_RegW,
  input  logic       id_ALUSrc,
  input  logic       id_MemW,
  input  logic       id_MemR,
  input  logic       id_MemtoReg,
  input  logic [1:0] id_ALUop,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       ex_Regdst,
  output logic       ex_RegW,
  output logic       ex_ALUSrc,
  output logic       ex_MemW,
  output logic       ex_MemR,
  output logic       ex_MemtoReg,
  output logic [1:0] ex_ALUop,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic       mem_MemW,
  output logic       mem_MemR,
  output logic       mem_RegW,
  output logic       mem_MemtoReg,
  output logic       wb_RegW,
  output logic       wb_MemtoReg,
  output logic [4:0] ex_wreg,
  output logic [4:0] mem_wreg,
  output logic [4:0] wb_wreg,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  id_ex_t            id_ex;
  ex_mem_t           ex_mem;
  mem_wb_t           mem_wb;
  logic [CTRL_W-1:0] id_ctrl;
  logic              take;

  assign id_ctrl = {id_Regdst, id_RegW, id_ALUSrc,
                    id_MemW, id_MemR, id_MemtoReg,
                    id_ALUop};

  assign take = id_valid & ~stall & ~flush;

  // Bubbles load all-zero, so invalid stages show zero controls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (take) begin
        id_ex.valid <= 1'b1;
        id_ex.ctrl  <= ctrl_t'(id_ctrl);
        id_ex.rs    <= id_rs;
        id_ex.rt    <= id_rt;
        id_ex.wreg  <= id_Regdst ? id_rd : id_rt;
      end else begin
        id_ex <= '0;
      end
      ex_mem.valid    <= id_ex.valid;
      ex_mem.memw     <= id_ex.ctrl.memw;
      ex_mem.memr     <= id_ex.ctrl.memr;
      ex_mem.regw     <= id_ex.ctrl.regw;
      ex_mem.memtoreg <= id_ex.ctrl.memtoreg;
      ex_mem.wreg     <= id_ex.wreg;
      mem_wb.valid    <= ex_mem.valid;
      mem_wb.regw     <= ex_mem.regw;
      mem_wb.memtoreg <= ex_mem.memtoreg;
      mem_wb.wreg     <= ex_mem.wreg;
    end
  end

  hazard_unit u_hazard (
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .flush     (flush),
    .ex_valid  (id_ex.valid),
    .ex_RegW   (id_ex.ctrl.regw),
    .ex_MemR   (id_ex.ctrl.memr),
    .ex_wreg   (id_ex.wreg),
    .ex_rs     (id_ex.rs),
    .ex_rt     (id_ex.rt),
    .mem_valid (ex_mem.valid),
    .mem_RegW  (ex_mem.regw),
    .mem_wreg  (ex_mem.wreg),
    .wb_valid  (mem_wb.valid),
    .wb_RegW   (mem_wb.regw),
    .wb_wreg   (mem_wb.wreg),
    .stall     (stall),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  assign ex_Regdst    = id_ex.ctrl.regdst;
  assign ex_RegW      = id_ex.ctrl.regw;
  assign ex_ALUSrc    = id_ex.ctrl.alusrc;
  assign ex_MemW      = id_ex.ctrl.memw;
  assign ex_MemR      = id_ex.ctrl.memr;
  assign ex_MemtoReg  = id_ex.ctrl.memtoreg;
  assign ex_ALUop     = id_ex.ctrl.aluop;
  assign ex_rs        = id_ex.rs;
  assign ex_rt        = id_ex.rt;
  assign ex_wreg      = id_ex.wreg;
  assign mem_MemW     = ex_mem.memw;
  assign mem_MemR     = ex_mem.memr;
  assign mem_RegW     = ex_mem.regw;
  assign mem_MemtoReg = ex_mem.memtoreg;
  assign mem_wreg     = ex_mem.wreg;
  assign wb_RegW      = mem_wb.regw;
  assign wb_MemtoReg  = mem_wb.memtoreg;
  assign wb_wreg      = mem_wb.wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Table-driven bench for ctrl_pipe with a per-stage scoreboard.
// Expectations follow the CTRL_PIPE_FWD_EN setting of the build.
`timescale 1ns/1ps
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic       id_Regdst, id_RegW, id_ALUSrc;
  logic       id_MemW, id_MemR, id_MemtoReg;
  logic [1:0] id_ALUop;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic       ex_Regdst, ex_RegW, ex_ALUSrc;
  logic       ex_MemW, ex_MemR, ex_MemtoReg;
  logic [1:0] ex_ALUop;
  logic [4:0] ex_rs, ex_rt;
  logic       mem_MemW, mem_MemR, mem_RegW, mem_MemtoReg;
  logic       wb_RegW, wb_MemtoReg;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_Regdst    (id_Regdst),
    .id_RegW      (id_RegW),
    .id_ALUSrc    (id_ALUSrc),
    .id_MemW      (id_MemW),
    .id_MemR      (id_MemR),
    .id_MemtoReg  (id_MemtoReg),
    .id_ALUop     (id_ALUop),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .flush        (flush),
    .ex_Regdst    (ex_Regdst),
    .ex_RegW      (ex_RegW),
    .ex_ALUSrc    (ex_ALUSrc),
    .ex_MemW      (ex_MemW),
    .ex_MemR      (ex_MemR),
    .ex_MemtoReg  (ex_MemtoReg),
    .ex_ALUop     (ex_ALUop),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_MemW     (mem_MemW),
    .mem_MemR     (mem_MemR),
    .mem_RegW     (mem_RegW),
    .mem_MemtoReg (mem_MemtoReg),
    .wb_RegW      (wb_RegW),
    .wb_MemtoReg  (wb_MemtoReg),
    .ex_wreg      (ex_wreg),
    .mem_wreg     (mem_wreg),
    .wb_wreg      (wb_wreg),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  logic [22:0] ex_obs;
  logic [8:0]  mem_obs;
  logic [6:0]  wb_obs;
  logic [43:0] all_obs;

  assign ex_obs = {ex_Regdst, ex_RegW, ex_ALUSrc, ex_MemW,
                   ex_MemR, ex_MemtoReg, ex_ALUop,
                   ex_rs, ex_rt, ex_wreg};
  assign mem_obs = {mem_MemW, mem_MemR, mem_RegW,
                    mem_MemtoReg, mem_wreg};
  assign wb_obs = {wb_RegW, wb_MemtoReg, wb_wreg};
  assign all_obs = {ex_obs, mem_obs, wb_obs,
                    stall, fwd_a, fwd_b};

  typedef struct {
    logic       v;
    logic [7:0] c;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       st;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    int          due;
    logic [22:0] val;
  } sb_t;

  vec_t tbl[$];
  sb_t  q_ex[$], q_mem[$], q_wb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [7:0] c,
                              int rs, int rt, int rd);
    vec_t t;
    t.v = v; t.c = c;
    t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.fl = 1'b0; t.st = 1'b0;
    t.fa = 2'b00; t.fb = 2'b00;
    return t;
  endfunction

  // c = {Regdst, RegW, ALUSrc, MemW, MemR, MemtoReg, ALUop}
  function automatic vec_t rr(int rs, int rt, int rd);
    return mk(1'b1, 8'b1100_0010, rs, rt, rd);
  endfunction

  function automatic vec_t lw(int rs, int rt);
    return mk(1'b1, 8'b0110_1100, rs, rt, 0);
  endfunction

  function automatic vec_t sw(int rs, int rt);
    return mk(1'b1, 8'b0011_0000, rs, rt, 0);
  endfunction

  function automatic vec_t nop();
    return mk(1'b0, 8'd0, 0, 0, 0);
  endfunction

  function automatic vec_t fl(vec_t t);
    t.fl = 1'b1;
    return t;
  endfunction

  function automatic void add(vec_t t, logic st,
                              logic [1:0] fa, logic [1:0] fb);
    t.st = st; t.fa = fa; t.fb = fb;
    tbl.push_back(t);
  endfunction

  function automatic void drain();
    for (int k = 0; k < 3; k++) add(nop(), 1'b0, 2'b00, 2'b00);
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v;
    {id_Regdst, id_RegW, id_ALUSrc, id_MemW,
     id_MemR, id_MemtoReg, id_ALUop} = t.c;
    id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    flush = t.fl;
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q_ex.size() > 0 && q_ex[0].due == cyc) begin
      e = q_ex.pop_front();
      chk($sformatf("ex_stage c%0d", cyc), 64'(ex_obs), 64'(e.val));
    end
    if (q_mem.size() > 0 && q_mem[0].due == cyc) begin
      e = q_mem.pop_front();
      chk($sformatf("mem_stage c%0d", cyc), 64'(mem_obs), 64'(e.val));
    end
    if (q_wb.size() > 0 && q_wb[0].due == cyc) begin
      e = q_wb.pop_front();
      chk($sformatf("wb_stage c%0d", cyc), 64'(wb_obs), 64'(e.val));
    end
  endtask

  task automatic step(input vec_t t, input int idx);
    sb_t        e;
    logic       acc;
    logic [4:0] w;
    drive(t);
    #1;
    chk($sformatf("stall r%0d", idx), 64'(stall), 64'(t.st));
    chk($sformatf("fwd_a r%0d", idx), 64'(fwd_a), 64'(t.fa));
    chk($sformatf("fwd_b r%0d", idx), 64'(fwd_b), 64'(t.fb));
    acc = t.v && !t.fl && !t.st;
    w = t.c[7] ? t.rd : t.rt;
    e.due = cyc + 1;
    e.val = acc ? {t.c, t.rs, t.rt, w} : 23'd0;
    q_ex.push_back(e);
    e.due = cyc + 2;
    e.val = acc ? {14'd0, t.c[4], t.c[3], t.c[6], t.c[2], w} : 23'd0;
    q_mem.push_back(e);
    e.due = cyc + 3;
    e.val = acc ? {16'd0, t.c[6], t.c[2], w} : 23'd0;
    q_wb.push_back(e);
    tick();
  endtask

  task automatic build();
    // load-use: lw r8 then add rs=8
    add(lw(1, 8), 0, 2'b00, 2'b00);
    add(rr(8, 2, 3), 1, 2'b00, 2'b00);
`ifdef CTRL_PIPE_FWD_EN
    add(rr(8, 2, 3), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b01, 2'b00);
`else
    add(rr(8, 2, 3), 1, 2'b00, 2'b00);
    add(rr(8, 2, 3), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b00, 2'b00);
`endif
    drain();
    // back-to-back add rd=9, sub rs=9
    add(rr(1, 2, 9), 0, 2'b00, 2'b00);
`ifdef CTRL_PIPE_FWD_EN
    add(rr(9, 4, 5), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b10, 2'b00);
`else
    add(rr(9, 4, 5), 1, 2'b00, 2'b00);
    add(rr(9, 4, 5), 1, 2'b00, 2'b00);
    add(rr(9, 4, 5), 0, 2'b00, 2'b00);
`endif
    drain();
    // one nop gap
    add(rr(1, 2, 9), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b00, 2'b00);
`ifdef CTRL_PIPE_FWD_EN
    add(rr(9, 9, 6), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b01, 2'b01);
`else
    add(rr(9, 9, 6), 1, 2'b00, 2'b00);
    add(rr(9, 9, 6), 0, 2'b00, 2'b00);
`endif
    drain();
    // MEM and WB both hold r9
    add(rr(1, 2, 9), 0, 2'b00, 2'b00);
    add(rr(3, 4, 9), 0, 2'b00, 2'b00);
`ifdef CTRL_PIPE_FWD_EN
    add(rr(9, 9, 7), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b10, 2'b10);
`else
    add(rr(9, 9, 7), 1, 2'b00, 2'b00);
    add(rr(9, 9, 7), 1, 2'b00, 2'b00);
    add(rr(9, 9, 7), 0, 2'b00, 2'b00);
`endif
    drain();
    // r0 never hazards
    add(rr(1, 2, 0), 0, 2'b00, 2'b00);
    add(rr(0, 0, 5), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b00, 2'b00);
    add(lw(1, 0), 0, 2'b00, 2'b00);
    add(rr(0, 3, 4), 0, 2'b00, 2'b00);
    drain();
    // load-use coincident with flush
    add(lw(1, 8), 0, 2'b00, 2'b00);
    add(fl(rr(8, 2, 3)), 0, 2'b00, 2'b00);
    add(nop(), 0, 2'b00, 2'b00);
    drain();
    // store timing
    add(sw(1, 2), 0, 2'b00, 2'b00);
    drain();
    // invalid ID with matching fields
    add(lw(1, 8), 0, 2'b00, 2'b00);
    add(mk(1'b0, 8'b1100_0010, 8, 8, 8), 0, 2'b00, 2'b00);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(rr(8, 8, 9));
    build();
    #2;
    chk("reset_state", 64'(all_obs), 64'd0);
    drive(nop());
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", 64'(all_obs), 64'd0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    drive(nop());
    tick();
    tick();
    chk("sb_drained", 64'(q_ex.size() + q_mem.size() + q_wb.size()), 64'd0);

    // fill three stages, then reset between edges
    drive(rr(1, 2, 3)); tick();
    drive(rr(4, 5, 6)); tick();
    drive(lw(7, 8));    tick();
    drive(rr(8, 8, 9));
    #1;
    chk("pre_reset_stall", 64'(stall), 64'd1);
    chk("pre_reset_full", 64'({ex_MemR, mem_RegW, wb_RegW}), 64'd7);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_now", 64'(all_obs), 64'd0);
    #4;
    chk("async_reset_hold", 64'(all_obs), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_over_edge", 64'(all_obs), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(nop());
    @(posedge clk);
    #1;
    chk("inflight_dropped", 64'(all_obs), 64'd0);
    drive(rr(1, 2, 3));
    @(posedge clk);
    #1;
    chk("resume_capture", 64'({ex_RegW, ex_wreg, mem_RegW}), 64'({1'b1, 5'd3, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
